redundant_digit_serializer: RTL and testbench

Sequential carry-resolver and serializer for the redundant multi-symbol words produced by the modular squarer datapath. Accepts one word of NUMSYMBOLS overlapping symbols, where each symbol is LOGRADIX digit bits plus EXTRABITS carry headroom. Resolves carries least-significant symbol first and streams canonical radix-2^LOGRADIX digits, one per handshake, ending with the final carry-out. It is the read side of the squarer's redundant symbol interface: it feeds checkers, host readback and bigmod comparison in benches.

---
 rtl/redundant_digit_serializer.sv | 62 ++++++
 tb/tb_redundant_digit_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/redundant_digit_serializer.sv
// redundant_digit_serializer: resolves carries across a redundant symbol word and streams canonical digits LSB first.
module redundant_digit_serializer #(
  parameter int LOGNUMSYMBOLS = 5,
  parameter int LOGRADIX = 33,
  parameter int EXTRABITS = 4,
  localparam int NUMSYMBOLS = 1 << LOGNUMSYMBOLS,
  localparam int SYMBOLWIDTH = LOGRADIX + EXTRABITS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUMSYMBOLS*SYMBOLWIDTH-1:0] in_symbols,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LOGRADIX-1:0]               out_digit,
  output logic [LOGNUMSYMBOLS-1:0]          out_index,
  output logic                              out_last,
  output logic [EXTRABITS:0]                out_carry
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, next_state;
  logic [NUMSYMBOLS*SYMBOLWIDTH-1:0] word_buf;
  logic [LOGNUMSYMBOLS-1:0] idx;
  logic [EXTRABITS:0] carry;
  logic [SYMBOLWIDTH:0] sum;
  logic run, last;
  always_comb begin
    run = state == RUN;
    sum = {1'b0, word_buf[SYMBOLWIDTH-1:0]} + (SYMBOLWIDTH+1)'(carry);
    last = idx == LOGNUMSYMBOLS'(NUMSYMBOLS - 1);
    next_state = state;
    if (!run && in_valid) next_state = RUN;
    if (run && out_ready && last) next_state = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      word_buf <= '0;
      idx <= '0;
      carry <= '0;
    end else begin
      state <= next_state;
      if (!run && in_valid) begin
        word_buf <= in_symbols;
        idx <= '0;
        carry <= '0;
      end else if (run && out_ready) begin
        carry <= sum[SYMBOLWIDTH:LOGRADIX];
        word_buf <= word_buf >> SYMBOLWIDTH;
        idx <= idx + 1'b1;
      end
    end
  end
  // Outputs are forced to zero outside RUN so idle leftovers never show.
  assign in_ready = !run;
  assign out_valid = run;
  assign out_digit = run ? sum[LOGRADIX-1:0] : '0;
  assign out_index = run ? idx : '0;
  assign out_last = run && last;
  assign out_carry = run ? sum[SYMBOLWIDTH:LOGRADIX] : '0;
endmodule

// File: tb/tb_redundant_digit_serializer.sv
// tb_redundant_digit_serializer: directed checks on a small instance, random bigint checks on a default instance.
module tb_redundant_digit_serializer;
  localparam int BN = 32;
  localparam int BR = 33;
  localparam int BW = 37;
  localparam int BT = BN * BR + 5;
  logic clk = 0;
  logic reset = 1;
  int n_checks = 0;
  int n_err = 0;
  always #5 clk = ~clk;

  logic s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0, s_out_last;
  logic [47:0] s_in_symbols = '0;
  logic [7:0] s_out_digit;
  logic [1:0] s_out_index;
  logic [4:0] s_out_carry;

  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_last;
  logic [BN*BW-1:0] b_in_symbols = '0;
  logic [BR-1:0] b_out_digit;
  logic [4:0] b_out_index;
  logic [4:0] b_out_carry;

  redundant_digit_serializer #(.LOGNUMSYMBOLS(2), .LOGRADIX(8), .EXTRABITS(4)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_symbols(s_in_symbols),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_digit(s_out_digit), .out_index(s_out_index),
    .out_last(s_out_last), .out_carry(s_out_carry));

  redundant_digit_serializer u_big (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_symbols(b_in_symbols),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_digit(b_out_digit), .out_index(b_out_index),
    .out_last(b_out_last), .out_carry(b_out_carry));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic s_send(input logic [47:0] w);
    int t = 0;
    while (!s_in_ready && t < 100) begin @(negedge clk); t++; end
    check("s_in_ready_wait", 64'(s_in_ready), 1);
    s_in_valid = 1;
    s_in_symbols = w;
    @(negedge clk);
    s_in_valid = 0;
  endtask

  // Expected digits come from the integer value of the word, not from any carry chain.
  task automatic s_stream(input logic [47:0] w, input int stall_at, input int stall_n, output logic [36:0] got);
    logic [36:0] total;
    int t = 0;
    total = '0;
    for (int i = 0; i < 4; i++) total += 37'(w[i*12 +: 12]) << (8 * i);
    got = '0;
    while (!s_out_valid && t < 20) begin @(negedge clk); t++; end
    check("s_valid_wait", 64'(s_out_valid), 1);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        s_out_ready = 0;
        for (int j = 0; j < stall_n; j++) begin
          @(negedge clk);
          check("stall_digit", 64'(s_out_digit), 64'(total[8*k +: 8]));
          check("stall_index", 64'(s_out_index), 64'(k));
          check("stall_in_ready", 64'(s_in_ready), 0);
        end
      end
      s_out_ready = 1;
      check("s_valid", 64'(s_out_valid), 1);
      check("s_in_ready_run", 64'(s_in_ready), 0);
      check("s_digit", 64'(s_out_digit), 64'(total[8*k +: 8]));
      check("s_index", 64'(s_out_index), 64'(k));
      check("s_last", 64'(s_out_last), 64'(k == 3));
      if (k == 3) check("s_carry", 64'(s_out_carry), 64'(total[36:32]));
      got |= 37'(s_out_digit) << (8 * k);
      if (k == 3) got |= 37'(s_out_carry) << 32;
      @(negedge clk);
    end
    s_out_ready = 0;
    check("s_done_valid", 64'(s_out_valid), 0);
    check("s_done_in_ready", 64'(s_in_ready), 1);
  endtask

  initial begin
    logic [47:0] cp, mx, wa, wb;
    logic [36:0] got;
    logic [BT-1:0] total;
    logic [BW-1:0] sym;
    int t;
    cp = {12'hFFF, 12'h000, 12'h0FF, 12'h1FF};
    mx = {4{12'hFFF}};
    wa = {12'h004, 12'h003, 12'h002, 12'h001};
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_in_ready", 64'(s_in_ready), 1);
    check("rst_out_valid", 64'(s_out_valid), 0);
    check("rst_digit", 64'(s_out_digit), 0);
    check("rst_index", 64'(s_out_index), 0);
    check("rst_last", 64'(s_out_last), 0);
    check("rst_carry", 64'(s_out_carry), 0);
    check("rst_big_in_ready", 64'(b_in_ready), 1);
    check("rst_big_valid", 64'(b_out_valid), 0);

    s_send(cp);
    s_stream(cp, -1, 0, got);
    check("carry_prop_total", 64'(got), 64'h0FFF0100FF);

    s_send(mx);
    s_stream(mx, -1, 0, got);
    check("headroom_total", 64'(got), 64'h100F0F0EFF);

    s_send(cp);
    s_stream(cp, 1, 3, got);
    check("backpressure_total", 64'(got), 64'h0FFF0100FF);

    s_send(cp);
    s_out_ready = 1;
    repeat (2) @(negedge clk);
    s_out_ready = 0;
    check("pre_reset_index", 64'(s_out_index), 2);
    reset = 1;
    s_out_ready = 1;
    @(negedge clk);
    reset = 0;
    s_out_ready = 0;
    check("mid_reset_valid", 64'(s_out_valid), 0);
    check("mid_reset_in_ready", 64'(s_in_ready), 1);
    @(negedge clk);
    check("mid_reset_stays_idle", 64'(s_out_valid), 0);
    s_send(wa);
    s_stream(wa, -1, 0, got);
    check("after_reset_total", 64'(got), 64'h0004030201);

    wb = {12'h7A5, 12'h3C3, 12'hE01, 12'h0FE};
    s_in_valid = 1;
    s_in_symbols = mx;
    @(negedge clk);
    s_in_valid = 0;
    s_in_symbols = wb;
    @(negedge clk);
    s_in_valid = 1;
    check("b2b_ignored_index", 64'(s_out_index), 0);
    check("b2b_ignored_in_ready", 64'(s_in_ready), 0);
    s_stream(mx, -1, 0, got);
    check("b2b_first_total", 64'(got), 64'h100F0F0EFF);
    @(negedge clk);
    s_in_valid = 0;
    check("b2b_second_captured", 64'(s_out_valid), 1);
    s_stream(wb, -1, 0, got);

    for (int n = 0; n < 1000; n++) begin
      total = '0;
      for (int i = 0; i < BN; i++) begin
        sym = {5'($urandom), 32'($urandom)};
        b_in_symbols[i*BW +: BW] = sym;
        total += BT'(sym) << (BR * i);
      end
      t = 0;
      while (!b_in_ready && t < 100) begin @(negedge clk); t++; end
      check("big_in_ready_wait", 64'(b_in_ready), 1);
      b_in_valid = 1;
      @(negedge clk);
      b_in_valid = 0;
      for (int k = 0; k < BN; k++) begin
        while ($urandom_range(3, 0) == 0) begin b_out_ready = 0; @(negedge clk); end
        b_out_ready = 1;
        check("big_valid", 64'(b_out_valid), 1);
        check("big_digit", 64'(b_out_digit), 64'(total[BR*k +: BR]));
        check("big_index", 64'(b_out_index), 64'(k));
        check("big_last", 64'(b_out_last), 64'(k == BN - 1));
        if (k == BN - 1) check("big_carry", 64'(b_out_carry), 64'(total[BT-1 -: 5]));
        @(negedge clk);
      end
      b_out_ready = 0;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
